serv_rf_sram_if: RTL and testbench



---
 rtl/serv_rf_pkg.sv | 27 ++
 rtl/serv_rf_wbuf.sv | 92 +++++++++
 rtl/serv_rf_sram_if.sv | 184 ++++++++++++++++++
 tb/tb_serv_rf_sram_if.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serv_rf_pkg.sv
// rtl/serv_rf_pkg.sv - shared constants, state encoding and address helper for serv_rf_sram_if
package serv_rf_pkg;

  localparam int GPR_COUNT = 32;
  localparam int CSR_COUNT = 4;

  localparam logic [5:0] CSR_MSCRATCH = 6'd32;
  localparam logic [5:0] CSR_MTVEC    = 6'd33;
  localparam logic [5:0] CSR_MEPC     = 6'd34;
  localparam logic [5:0] CSR_MTVAL    = 6'd35;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RUN   = 2'd2,
    ST_WTAIL = 2'd3
  } rf_state_e;

  localparam logic [5:0] CNT_LAST_BIT  = 6'd31;
  localparam logic [5:0] CNT_LAST_TAIL = 6'd33;

  // SRAM address = {register, word}; l = log2(WIDTH), so a register spans 2^(5-l) words.
  function automatic logic [15:0] rf_addr(input logic [5:0] regno, input logic [4:0] word, input int l);
    return (16'(regno) << (5 - l)) | 16'(word);
  endfunction

endpackage

// File: rtl/serv_rf_wbuf.sv
// rtl/serv_rf_wbuf.sv - serial write gathering for both ports, port-1 holding stage and SRAM write mux
// SERV_RF_ZERO_X0_EN: when defined, writes targeting register 0 are never armed.
module serv_rf_wbuf
  import serv_rf_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int R     = 6,
  parameter int AW    = 10
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             shift_i,
  input  logic             last_i,
  input  logic [4:0]       word_i,
  input  logic [R-1:0]     wreg0_i,
  input  logic [R-1:0]     wreg1_i,
  input  logic             wen0_i,
  input  logic             wen1_i,
  input  logic             wdata0_i,
  input  logic             wdata1_i,
  output logic             wen_o,
  output logic [AW-1:0]    waddr_o,
  output logic [WIDTH-1:0] wdata_o
);

  localparam int L = $clog2(WIDTH);

  logic [WIDTH-1:0] g0_q, g1_q, g0_d, g1_d;
  logic [WIDTH-1:0] p0_data_q, p1a_data_q, p1b_data_q;
  logic [AW-1:0]    p0_addr_q, p1a_addr_q, p1b_addr_q;
  logic             p0_v_q, p1a_v_q, p1b_v_q;
  logic             ok0, ok1;

`ifdef SERV_RF_ZERO_X0_EN
  assign ok0 = wreg0_i != '0;
  assign ok1 = wreg1_i != '0;
`else
  assign ok0 = 1'b1;
  assign ok1 = 1'b1;
`endif

  // LSB-first serial data enters at the top, so a full word ends up in natural bit order.
  assign g0_d = WIDTH'({wdata0_i, g0_q} >> 1);
  assign g1_d = WIDTH'({wdata1_i, g1_q} >> 1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      g0_q       <= '0;
      g1_q       <= '0;
      p0_v_q     <= 1'b0;
      p1a_v_q    <= 1'b0;
      p1b_v_q    <= 1'b0;
      p0_data_q  <= '0;
      p1a_data_q <= '0;
      p1b_data_q <= '0;
      p0_addr_q  <= '0;
      p1a_addr_q <= '0;
      p1b_addr_q <= '0;
    end else begin
      if (shift_i) begin
        g0_q <= g0_d;
        g1_q <= g1_d;
      end
      p0_v_q  <= last_i & wen0_i & ok0;
      p1a_v_q <= last_i & wen1_i & ok1;
      p1b_v_q <= p1a_v_q;
      if (last_i) begin
        p0_data_q  <= g0_d;
        p0_addr_q  <= AW'(rf_addr(6'(wreg0_i), word_i, L));
        p1a_data_q <= g1_d;
        p1a_addr_q <= AW'(rf_addr(6'(wreg1_i), word_i, L));
      end
      // Port 1 waits one extra cycle so it lands after port 0's write of the same word.
      p1b_data_q <= p1a_data_q;
      p1b_addr_q <= p1a_addr_q;
    end
  end

  always_comb begin
    wen_o   = p0_v_q | p1b_v_q;
    waddr_o = '0;
    wdata_o = '0;
    if (p0_v_q) begin
      waddr_o = p0_addr_q;
      wdata_o = p0_data_q;
    end else if (p1b_v_q) begin
      waddr_o = p1b_addr_q;
      wdata_o = p1b_data_q;
    end
  end

endmodule

// File: rtl/serv_rf_sram_if.sv
// rtl/serv_rf_sram_if.sv - bit-serial register file ports mapped onto a 1R1W SRAM of WIDTH-bit words
// SERV_RF_ZERO_X0_EN: when defined, register 0 reads as zero and is never written.
module serv_rf_sram_if
  import serv_rf_pkg::*;
#(
  parameter  int WIDTH    = 2,
  parameter  int WITH_CSR = 1,
  localparam int R        = 5 + WITH_CSR,
  localparam int DEPTH    = (GPR_COUNT + CSR_COUNT * WITH_CSR) * 32 / WIDTH,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rreq,
  input  logic             i_wreq,
  output logic             o_ready,
  input  logic [R-1:0]     i_wreg0,
  input  logic [R-1:0]     i_wreg1,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic             i_wdata0,
  input  logic             i_wdata1,
  input  logic [R-1:0]     i_rreg0,
  input  logic [R-1:0]     i_rreg1,
  output logic             o_rdata0,
  output logic             o_rdata1,
  output logic [AW-1:0]    o_waddr,
  output logic [WIDTH-1:0] o_wdata,
  output logic             o_wen,
  output logic [AW-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [WIDTH-1:0] i_rdata
);

  localparam int         L         = $clog2(WIDTH);
  localparam logic [5:0] LO_MASK   = 6'(WIDTH - 1);
  localparam logic [5:0] LO_P0     = 6'(WIDTH - 2);
  localparam logic [5:0] LO_P1     = 6'(WIDTH - 1);
  localparam logic [4:0] LAST_WORD = 5'(31 / WIDTH);

  rf_state_e        state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             is_read_q;
  logic [R-1:0]     rreg0_q, rreg1_q, wreg0_q, wreg1_q;
  logic [WIDTH-1:0] sh0_q, sh1_q;
  logic [5:0]       cnt_lo;
  logic [4:0]       word;
  logic             run, start, last_bit;
  logic             rd0_zero, rd1_zero;

  function automatic logic [AW-1:0] word_addr(input logic [R-1:0] regno, input logic [4:0] w);
    return AW'(rf_addr(6'(regno), w, L));
  endfunction

  assign cnt_lo   = cnt_q & LO_MASK;
  assign word     = cnt_q[4:0] >> L;
  assign run      = state_q == ST_RUN;
  assign start    = (state_q == ST_IDLE) && (i_rreq || i_wreq);
  assign last_bit = run && (cnt_lo == LO_P1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_ready = 1'b0;
    o_ren   = 1'b0;
    o_raddr = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_rreq) begin
          o_ren   = 1'b1;
          o_raddr = word_addr(i_rreg0, 5'd0);
          state_d = ST_REQ;
        end else if (i_wreq) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        o_ready = 1'b1;
        cnt_d   = '0;
        state_d = ST_RUN;
        if (is_read_q) begin
          o_ren   = 1'b1;
          o_raddr = word_addr(rreg1_q, 5'd0);
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == CNT_LAST_BIT) state_d = ST_WTAIL;
        // Port 0 fetches one cycle ahead of port 1 so both words are ready at the next word boundary.
        if (is_read_q && word != LAST_WORD) begin
          if (cnt_lo == LO_P0) begin
            o_ren   = 1'b1;
            o_raddr = word_addr(rreg0_q, word + 5'd1);
          end else if (cnt_lo == LO_P1) begin
            o_ren   = 1'b1;
            o_raddr = word_addr(rreg1_q, word + 5'd1);
          end
        end
      end
      ST_WTAIL: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == CNT_LAST_TAIL) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      is_read_q <= 1'b0;
      rreg0_q   <= '0;
      rreg1_q   <= '0;
      wreg0_q   <= '0;
      wreg1_q   <= '0;
    end else if (start) begin
      is_read_q <= i_rreq;
      rreg0_q   <= i_rreg0;
      rreg1_q   <= i_rreg1;
      wreg0_q   <= i_wreg0;
      wreg1_q   <= i_wreg1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh0_q <= '0;
      sh1_q <= '0;
    end else if (state_q == ST_REQ && is_read_q) begin
      sh0_q <= i_rdata;
    end else if (run) begin
      if (is_read_q && cnt_lo == LO_P1 && word != LAST_WORD) sh0_q <= i_rdata;
      else                                                   sh0_q <= sh0_q >> 1;
      // Port 1's word arrives exactly at the word boundary: bit 0 goes straight out, the rest is held.
      if (cnt_lo == '0) sh1_q <= i_rdata >> 1;
      else              sh1_q <= sh1_q >> 1;
    end
  end

`ifdef SERV_RF_ZERO_X0_EN
  assign rd0_zero = rreg0_q == '0;
  assign rd1_zero = rreg1_q == '0;
`else
  assign rd0_zero = 1'b0;
  assign rd1_zero = 1'b0;
`endif

  assign o_rdata0 = run & is_read_q & ~rd0_zero & sh0_q[0];
  assign o_rdata1 = run & is_read_q & ~rd1_zero & ((cnt_lo == '0) ? i_rdata[0] : sh1_q[0]);

  serv_rf_wbuf #(
    .WIDTH (WIDTH),
    .R     (R),
    .AW    (AW)
  ) u_wbuf (
    .clk_i    (i_clk),
    .rst_n_i  (i_rst_n),
    .shift_i  (run),
    .last_i   (last_bit),
    .word_i   (word),
    .wreg0_i  (wreg0_q),
    .wreg1_i  (wreg1_q),
    .wen0_i   (i_wen0),
    .wen1_i   (i_wen1),
    .wdata0_i (i_wdata0),
    .wdata1_i (i_wdata1),
    .wen_o    (o_wen),
    .waddr_o  (o_waddr),
    .wdata_o  (o_wdata)
  );

endmodule

// File: tb/tb_serv_rf_sram_if.sv
// tb/tb_serv_rf_sram_if.sv - directed bench for serv_rf_sram_if (WIDTH=2, WITH_CSR=1) with SRAM and register model
module tb_serv_rf_sram_if;

  localparam int WIDTH = 2;
  localparam int R     = 6;
  localparam int AW    = 10;
  localparam int DEPTH = 576;
  localparam int WPR   = 32 / WIDTH;
`ifdef SERV_RF_ZERO_X0_EN
  localparam bit ZX = 1'b1;
`else
  localparam bit ZX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rreq = 1'b0, wreq = 1'b0;
  logic wen0 = 1'b0, wen1 = 1'b0, wdata0 = 1'b0, wdata1 = 1'b0;
  logic [R-1:0] wreg0 = '0, wreg1 = '0, rreg0 = '0, rreg1 = '0;
  logic ready, rdata0, rdata1, wen, ren;
  logic [AW-1:0] waddr, raddr;
  logic [WIDTH-1:0] wdata_s, rdata_s;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [31:0] ref_rf [36];
  logic preload = 1'b0;
  int wcount = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serv_rf_sram_if #(.WIDTH(WIDTH), .WITH_CSR(1)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_rreq   (rreq),
    .i_wreq   (wreq),
    .o_ready  (ready),
    .i_wreg0  (wreg0),
    .i_wreg1  (wreg1),
    .i_wen0   (wen0),
    .i_wen1   (wen1),
    .i_wdata0 (wdata0),
    .i_wdata1 (wdata1),
    .i_rreg0  (rreg0),
    .i_rreg1  (rreg1),
    .o_rdata0 (rdata0),
    .o_rdata1 (rdata1),
    .o_waddr  (waddr),
    .o_wdata  (wdata_s),
    .o_wen    (wen),
    .o_raddr  (raddr),
    .o_ren    (ren),
    .i_rdata  (rdata_s)
  );

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_rf[i / WPR][(i % WPR) * WIDTH +: WIDTH];
    end else if (wen) begin
      mem[waddr] <= wdata_s;
    end
    if (ren) rdata_s <= mem[raddr];
    if (wen) wcount <= wcount + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [5:0] r);
    return (ZX && r == 6'd0) ? 32'd0 : ref_rf[r];
  endfunction

  // Starts at a negedge in request cycle C and returns at the negedge of C+36.
  task automatic xfer(input string tag, input bit rq, input bit wq, input bit poke,
                      input logic [5:0] rr0, input logic [5:0] rr1,
                      input logic [5:0] wr0, input logic [5:0] wr1,
                      input logic [31:0] wd0, input logic [31:0] wd1,
                      input logic [31:0] m0, input logic [31:0] m1);
    logic [31:0] got0, got1, e0, e1;
    logic [AW-1:0] ea;
    logic [WIDTH-1:0] ed;
    bit ee;
    int w, nexp, wstart;
    e0 = exp_rd(rr0);
    e1 = exp_rd(rr1);
    nexp = 0;
    got0 = '0;
    got1 = '0;
    rreq = rq; wreq = wq;
    rreg0 = rr0; rreg1 = rr1; wreg0 = wr0; wreg1 = wr1;
    #1;
    check({tag, ".ren_c"}, 32'(ren), 32'(rq));
    if (rq) check({tag, ".raddr_c"}, 32'(raddr), 32'(rr0) * WPR);
    @(negedge clk);
    rreq = poke; wreq = 1'b0;
    check({tag, ".ready"}, 32'(ready), 32'd1);
    wstart = wcount;
    for (int n = 0; n < 34; n++) begin
      @(negedge clk);
      if (n < 32) begin
        wdata0 = wd0[n]; wen0 = m0[n]; wdata1 = wd1[n]; wen1 = m1[n];
        got0[n] = rdata0; got1[n] = rdata1;
      end else begin
        wdata0 = 1'b0; wen0 = 1'b0; wdata1 = 1'b0; wen1 = 1'b0;
      end
      ee = 1'b0; ea = '0; ed = '0;
      if (n >= 2 && n % 2 == 0) begin
        w  = (n - 2) / 2;
        ee = m0[WIDTH * w + WIDTH - 1] && !(ZX && wr0 == 6'd0);
        ea = AW'(int'(wr0) * WPR + w);
        ed = wd0[WIDTH * w +: WIDTH];
      end else if (n >= 3 && n % 2 == 1) begin
        w  = (n - 3) / 2;
        ee = m1[WIDTH * w + WIDTH - 1] && !(ZX && wr1 == 6'd0);
        ea = AW'(int'(wr1) * WPR + w);
        ed = wd1[WIDTH * w +: WIDTH];
      end
      if (ee) nexp++;
      check({tag, ".ready_low"}, 32'(ready), 32'd0);
      check({tag, ".wen"}, 32'(wen), 32'(ee));
      if (ee) begin
        check({tag, ".waddr"}, 32'(waddr), 32'(ea));
        check({tag, ".wdata"}, 32'(wdata_s), 32'(ed));
      end
    end
    @(negedge clk);
    rreq = 1'b0;
    check({tag, ".wen_end"}, 32'(wen), 32'd0);
    check({tag, ".ready_end"}, 32'(ready), 32'd0);
    check({tag, ".nwrites"}, 32'(wcount - wstart), 32'(nexp));
    if (rq) begin
      check({tag, ".rdata0"}, got0, e0);
      check({tag, ".rdata1"}, got1, e1);
    end
    for (int k = 0; k < WPR; k++) begin
      if (m0[WIDTH * k + WIDTH - 1] && !(ZX && wr0 == 6'd0)) ref_rf[wr0][WIDTH * k +: WIDTH] = wd0[WIDTH * k +: WIDTH];
    end
    for (int k = 0; k < WPR; k++) begin
      if (m1[WIDTH * k + WIDTH - 1] && !(ZX && wr1 == 6'd0)) ref_rf[wr1][WIDTH * k +: WIDTH] = wd1[WIDTH * k +: WIDTH];
    end
  endtask

  initial begin
    for (int i = 0; i < 36; i++) ref_rf[i] = 32'd0;
    ref_rf[5]  = 32'hDEADBEEF;
    ref_rf[6]  = 32'h12345678;
    ref_rf[9]  = 32'h11111111;
    ref_rf[10] = 32'h22222222;
    #2;
    check("rst.ready", 32'(ready), 32'd0);
    check("rst.wen", 32'(wen), 32'd0);
    check("rst.ren", 32'(ren), 32'd0);
    check("rst.rdata0", 32'(rdata0), 32'd0);
    check("rst.rdata1", 32'(rdata1), 32'd0);
    check("rst.waddr", 32'(waddr), 32'd0);
    check("rst.raddr", 32'(raddr), 32'd0);
    check("rst.wdata", 32'(wdata_s), 32'd0);
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    xfer("rd56",   1, 0, 0, 6'd5, 6'd6, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    xfer("wr73",   0, 1, 0, 6'd0, 6'd0, 6'd7, 6'd3, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'hFFFFFFFF);
    xfer("rd73",   1, 1, 0, 6'd7, 6'd3, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    xfer("wrpart", 0, 1, 0, 6'd0, 6'd0, 6'd9, 6'd10, 32'hCAFEBABE, 32'hFFFFFFFF, 32'hFFFF0000, 32'h0);
    xfer("rdbusy", 1, 0, 1, 6'd9, 6'd10, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("busy.ready", 32'(ready), 32'd0);
    check("busy.ren", 32'(ren), 32'd0);
    xfer("wrx0",   0, 1, 0, 6'd0, 6'd0, 6'd0, 6'd11, 32'hFFFFFFFF, 32'h76543210, 32'hFFFFFFFF, 32'hFFFFFFFF);
    xfer("rdx0",   1, 0, 0, 6'd0, 6'd11, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0);

    // write to x12/x13 cut by reset in C+10
    wreq = 1'b1; wreg0 = 6'd12; wreg1 = 6'd13;
    @(negedge clk);
    wreq = 1'b0;
    for (int n = 0; n <= 8; n++) begin
      @(negedge clk);
      wdata0 = 1'b1; wen0 = 1'b1; wdata1 = 1'b1; wen1 = 1'b1;
    end
    check("rstmid.wen_before", 32'(wen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid.wen", 32'(wen), 32'd0);
    check("rstmid.ready", 32'(ready), 32'd0);
    wdata0 = 1'b0; wen0 = 1'b0; wdata1 = 1'b0; wen1 = 1'b0;
    ref_rf[12] = 32'h0000003F;
    ref_rf[13] = 32'h0000003F;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer("rdrst",  1, 0, 0, 6'd5, 6'd6, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    xfer("rdpart", 1, 0, 0, 6'd12, 6'd13, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    xfer("wrcsr",  0, 1, 0, 6'd0, 6'd0, 6'd35, 6'd32, 32'h13579BDF, 32'h2468ACE0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    xfer("rdcsr",  1, 0, 0, 6'd35, 6'd32, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
